// File: rtl/uart_receiver.sv
// 8N1 serial receiver with input synchronizer and a one-entry holding register.
// data_valid/data_ack: a byte is taken on any clk edge where both are high; data_out holds while data_valid=1.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 1,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rx,
   input  logic       data_ack,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       framing_error,
   output logic       overrun
);

   localparam logic [15:0] MID  = 16'(CLKS_PER_BIT / 2);
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [1:0]  FILL = 2'(SYNC_STAGES);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   rx_s;
   logic [1:0]             fill;
   logic                   armed;
   logic [15:0]            cnt;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift;

   assign rx_s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '1;
      end else begin
         sync[0] <= uart_rx;
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         armed         <= 1'b0;
         fill          <= 2'd0;
         cnt           <= 16'd0;
         bit_cnt       <= 3'd0;
         shift         <= 8'd0;
         data_out      <= 8'd0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         framing_error <= 1'b0;
         overrun       <= 1'b0;
         // The synchronizer's reset ones are not line samples; never arm on them.
         if (fill != FILL) fill <= fill + 2'd1;
         if (data_ack && data_valid) data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_s && fill == FILL) armed <= 1'b1;
               if (armed && !rx_s) begin
                  bit_cnt <= 3'd0;
                  if (MID == 16'd0) begin
                     state <= DATA;
                     cnt   <= 16'd0;
                  end else begin
                     state <= START;
                     cnt   <= 16'd1;
                  end
               end
            end
            START: begin
               if (cnt == MID && rx_s) begin
                  state <= IDLE;
                  cnt   <= 16'd0;
               end else if (cnt == LAST) begin
                  state <= DATA;
                  cnt   <= 16'd0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (cnt == MID) shift <= {rx_s, shift[7:1]};
               if (cnt == LAST) begin
                  cnt     <= 16'd0;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            STOP: begin
               if (cnt == MID) begin
                  state <= IDLE;
                  cnt   <= 16'd0;
                  if (!rx_s) begin
                     framing_error <= 1'b1;
                     armed         <= 1'b0;
                  end else if (!data_valid || data_ack) begin
                     data_out   <= shift;
                     data_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a fast (1 clk/bit) and a slow (16 clk/bit) instance
// checked every cycle against a frame-level model of the holding register.
module tb_uart_receiver;

   localparam int SYNC = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] rx_line;
   logic [1:0] ack_line;
   wire  [7:0] dout [2];
   wire  [1:0] dvalid;
   wire  [1:0] ferr;
   wire  [1:0] ovr;

   uart_receiver #(.CLKS_PER_BIT(1), .SYNC_STAGES(SYNC)) u_fast (
      .clk(clk), .reset(rst), .uart_rx(rx_line[0]), .data_ack(ack_line[0]),
      .data_out(dout[0]), .data_valid(dvalid[0]), .framing_error(ferr[0]), .overrun(ovr[0])
   );

   uart_receiver #(.CLKS_PER_BIT(16), .SYNC_STAGES(SYNC)) u_slow (
      .clk(clk), .reset(rst), .uart_rx(rx_line[1]), .data_ack(ack_line[1]),
      .data_out(dout[1]), .data_valid(dvalid[1]), .framing_error(ferr[1]), .overrun(ovr[1])
   );

   typedef struct {
      int         inst;
      int         cyc;
      logic       good;
      logic [7:0] b;
   } ev_t;

   ev_t        ev_q[$];
   logic [8:0] exp_q[$];
   logic       m_valid [2];
   logic       m_fe [2];
   logic       m_ov [2];
   logic [7:0] m_data [2];
   logic       auto_ack [2];
   int         ack_at [2];
   int         cyc_n;
   int         errors;
   int         checks;

   function automatic int lat(input int cpb);
      return SYNC + 9 * cpb + cpb / 2 + 1;
   endfunction

   task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] at cycle %0d: observed %0h expected %0h", tag, i, cyc_n, obs, exp);
      end
   endtask

   // One clock: advance the model to the coming edge, step, then compare everything.
   task automatic tick();
      for (int i = 0; i < 2; i++) begin
         logic       found;
         logic       good;
         logic [7:0] b;
         int         k;
         found = 1'b0;
         good  = 1'b0;
         b     = 8'd0;
         for (int j = ev_q.size() - 1; j >= 0; j--) begin
            if (ev_q[j].inst == i && ev_q[j].cyc == cyc_n + 1) begin
               found = 1'b1;
               good  = ev_q[j].good;
               b     = ev_q[j].b;
               ev_q.delete(j);
            end
         end
         m_fe[i] = 1'b0;
         m_ov[i] = 1'b0;
         if (rst) begin
            m_valid[i] = 1'b0;
            m_data[i]  = 8'd0;
         end else begin
            if (ack_line[i] && m_valid[i]) begin
               k = -1;
               for (int j = 0; j < exp_q.size(); j++)
                  if (k < 0 && exp_q[j][8] == i[0]) k = j;
               if (k >= 0) begin
                  chk("consumed_byte", i, dout[i], exp_q[k][7:0]);
                  exp_q.delete(k);
               end
               m_valid[i] = 1'b0;
            end
            if (found && good) begin
               if (!m_valid[i]) begin
                  m_data[i]  = b;
                  m_valid[i] = 1'b1;
                  exp_q.push_back({i[0], b});
               end else begin
                  m_ov[i] = 1'b1;
               end
            end else if (found) begin
               m_fe[i] = 1'b1;
            end
         end
      end
      if (rst) begin
         ev_q.delete();
         exp_q.delete();
      end
      @(posedge clk);
      #1;
      cyc_n++;
      for (int i = 0; i < 2; i++) begin
         chk("data_out", i, dout[i], m_data[i]);
         chk("data_valid", i, {7'd0, dvalid[i]}, {7'd0, m_valid[i]});
         chk("framing_error", i, {7'd0, ferr[i]}, {7'd0, m_fe[i]});
         chk("overrun", i, {7'd0, ovr[i]}, {7'd0, m_ov[i]});
      end
      for (int i = 0; i < 2; i++)
         ack_line[i] = (auto_ack[i] && m_valid[i]) || (ack_at[i] == cyc_n + 1);
   endtask

   task automatic send_frame(input int i, input logic [7:0] b, input logic stop_bit,
                             input logic expect_it, input logic ack_done);
      int         cpb;
      logic [9:0] frame;
      ev_t        e;
      cpb   = (i == 0) ? 1 : 16;
      frame = {stop_bit, b, 1'b0};
      if (expect_it) begin
         e.inst = i;
         e.cyc  = cyc_n + lat(cpb);
         e.good = stop_bit;
         e.b    = b;
         ev_q.push_back(e);
         if (ack_done) ack_at[i] = e.cyc;
      end
      for (int k = 0; k < 10; k++) begin
         rx_line[i] = frame[k];
         repeat (cpb) tick();
      end
   endtask

   task automatic idle(input int i, input int n);
      rx_line[i] = 1'b1;
      repeat (n) tick();
   endtask

   task automatic ack_once(input int i);
      ack_line[i] = 1'b1;
      tick();
   endtask

   initial begin
      logic [7:0] partial;
      errors   = 0;
      checks   = 0;
      cyc_n    = 0;
      rst      = 1'b1;
      rx_line  = 2'b11;
      ack_line = 2'b00;
      for (int i = 0; i < 2; i++) begin
         auto_ack[i] = 1'b0;
         ack_at[i]   = -1;
         m_valid[i]  = 1'b0;
         m_fe[i]     = 1'b0;
         m_ov[i]     = 1'b0;
         m_data[i]   = 8'd0;
      end
      repeat (3) tick();
      rst = 1'b0;
      repeat (4) tick();

      // single byte, then a one-cycle ack
      send_frame(0, 8'hDA, 1'b1, 1'b1, 1'b0);
      idle(0, 3);
      ack_once(0);
      idle(0, 2);

      // back-to-back frames, each byte acked as it appears
      auto_ack[0] = 1'b1;
      send_frame(0, 8'hDA, 1'b1, 1'b1, 1'b0);
      send_frame(0, 8'h5E, 1'b1, 1'b1, 1'b0);
      idle(0, 4);
      auto_ack[0] = 1'b0;

      // overrun, then ack coinciding with the third byte's load
      send_frame(0, 8'h11, 1'b1, 1'b1, 1'b0);
      send_frame(0, 8'h22, 1'b1, 1'b1, 1'b0);
      send_frame(0, 8'h33, 1'b1, 1'b1, 1'b1);
      idle(0, 4);
      ack_once(0);
      idle(0, 2);

      // framing error followed by a break; recovery once the line idles
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0);
      rx_line[0] = 1'b0;
      repeat (20) tick();
      idle(0, 4);
      send_frame(0, 8'h3C, 1'b1, 1'b1, 1'b0);
      idle(0, 4);
      ack_once(0);
      idle(0, 2);

      // slow line: short glitch is rejected, full frame is received
      rx_line[1] = 1'b0;
      repeat (3) tick();
      idle(1, 40);
      send_frame(1, 8'h81, 1'b1, 1'b1, 1'b0);
      idle(1, 20);
      ack_once(1);
      idle(1, 2);

      // reset after bit 3 of a frame, line then held low
      send_frame(0, 8'h77, 1'b1, 1'b1, 1'b0);
      idle(0, 3);
      partial    = 8'hC3;
      rx_line[0] = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         rx_line[0] = partial[k];
         tick();
      end
      rst        = 1'b1;
      rx_line[0] = 1'b0;
      tick();
      rst = 1'b0;
      repeat (6) tick();
      idle(0, 5);
      send_frame(0, 8'h5A, 1'b1, 1'b1, 1'b0);
      idle(0, 4);
      ack_once(0);
      idle(0, 2);

      // random bytes, stop bits, gaps and ack behaviour
      for (int n = 0; n < 40; n++) begin
         logic [7:0] b;
         logic       sb;
         int         gap;
         b           = 8'($urandom);
         sb          = ($urandom_range(0, 3) != 0);
         auto_ack[0] = 1'($urandom_range(0, 1));
         gap         = $urandom_range(sb ? 0 : 1, 3);
         send_frame(0, b, sb, 1'b1, 1'b0);
         idle(0, gap);
      end
      auto_ack[0] = 1'b1;
      idle(0, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
